// File: rtl/rd_burst_issuer.sv
// AXI4 read-burst issuer: splits burst/tail read requests into AR bursts of at most
// MAX_BEATS, counts R beats to completion and owns the frame address/beat bookkeeping.
module rd_burst_issuer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 8,
  parameter int ARSIZE     = 3,
  parameter int LSIZE      = 9,
  parameter int FSIZE      = 24,
  parameter int BURST_LEN  = 100,
  parameter int MAX_BEATS  = 64
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  fsync,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [FSIZE-1:0]      frame_beats,
  input  logic                  burst_req,
  input  logic                  tail_req,
  input  logic [LSIZE-1:0]      req_len,
  output logic                  resp,
  output logic                  done,
  output logic                  tail_status,
  output logic [LSIZE-1:0]      tail_len,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast
);

  // Wide enough for both a request length and a full 256-beat burst
  localparam int BW = (LSIZE > 9) ? LSIZE : 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   cur_addr_r, cur_addr_s;
  logic [FSIZE-1:0]        remaining_r, remaining_s;
  logic [LSIZE-1:0]        len_left_r, len_left_s;
  logic                    abort_r, abort_s;
  logic [ADDR_WIDTH-1:0]   araddr_r, araddr_s;
  logic [7:0]              arlen_r, arlen_s;
  logic                    arvalid_r, arvalid_s;
  logic                    resp_r, resp_s;
  logic                    done_r, done_s;
  logic                    busy_r, busy_s;
  logic                    tail_status_r, tail_status_s;
  logic [LSIZE-1:0]        tail_len_r, tail_len_s;
  logic [BW-1:0]           beats_s;
  logic                    r_last_s;

  assign r_last_s = rvalid & rready & rlast;

  // Beats for the next AR: outstanding request length capped at MAX_BEATS
  always_comb begin
    if (BW'(len_left_r) > BW'(MAX_BEATS)) begin
      beats_s = BW'(MAX_BEATS);
    end else begin
      beats_s = BW'(len_left_r);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    len_left_s  = len_left_r;
    abort_s     = abort_r;
    araddr_s    = araddr_r;
    arlen_s     = arlen_r;
    arvalid_s   = arvalid_r;
    resp_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fsync) begin
          state_s = IDLE;
        end else if (burst_req || tail_req) begin
          resp_s     = 1'b1;
          len_left_s = req_len;
          abort_s    = 1'b0;
          if (req_len == {LSIZE{1'b0}}) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!arvalid_r) begin
          if (fsync) begin
            state_s = IDLE;
          end else begin
            arvalid_s = 1'b1;
            araddr_s  = cur_addr_r;
            arlen_s   = 8'(beats_s - BW'(1));
          end
        end else if (arready) begin
          arvalid_s = 1'b0;
          // An aborted burst still has to be drained but must not touch the frame counters
          if (fsync || abort_r) begin
            state_s = DRAIN;
          end else begin
            cur_addr_s = cur_addr_r + ADDR_WIDTH'(beats_s) * ADDR_WIDTH'(DATA_BYTES);
            len_left_s = len_left_r - LSIZE'(beats_s);
            state_s    = DATA;
            if (32'(remaining_r) > 32'(beats_s)) begin
              remaining_s = remaining_r - FSIZE'(beats_s);
            end else begin
              remaining_s = {FSIZE{1'b0}};
            end
          end
        end else begin
          abort_s = abort_r | fsync;
        end
      end
      DATA: begin
        if (r_last_s) begin
          if (fsync) begin
            state_s = IDLE;
          end else if (len_left_r != {LSIZE{1'b0}}) begin
            state_s = ISSUE;
          end else begin
            done_s  = 1'b1;
            state_s = IDLE;
          end
        end else if (fsync) begin
          state_s = DRAIN;
        end else begin
          state_s = DATA;
        end
      end
      DRAIN: begin
        if (r_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status derived from the registered remaining count, so it lags it by a cycle
  always_comb begin
    tail_status_s = (32'(remaining_r) <= 32'(BURST_LEN));
    tail_len_s    = LSIZE'(remaining_r);
    busy_s        = (state_s != IDLE);
  end

  // State register; fsync reload has priority over every other counter update
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cur_addr_r    <= {ADDR_WIDTH{1'b0}};
      remaining_r   <= {FSIZE{1'b0}};
      len_left_r    <= {LSIZE{1'b0}};
      abort_r       <= 1'b0;
      araddr_r      <= {ADDR_WIDTH{1'b0}};
      arlen_r       <= 8'd0;
      arvalid_r     <= 1'b0;
      resp_r        <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      tail_status_r <= 1'b0;
      tail_len_r    <= {LSIZE{1'b0}};
    end else begin
      state_r       <= state_s;
      cur_addr_r    <= fsync ? base_addr : cur_addr_s;
      remaining_r   <= fsync ? frame_beats : remaining_s;
      len_left_r    <= len_left_s;
      abort_r       <= abort_s;
      araddr_r      <= araddr_s;
      arlen_r       <= arlen_s;
      arvalid_r     <= arvalid_s;
      resp_r        <= resp_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
      tail_status_r <= tail_status_s;
      tail_len_r    <= tail_len_s;
    end
  end

  assign resp        = resp_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign tail_status = tail_status_r;
  assign tail_len    = tail_len_r;
  assign araddr      = araddr_r;
  assign arlen       = arlen_r;
  assign arvalid     = arvalid_r;
  assign arsize      = 3'(ARSIZE);
  assign arburst     = 2'b01;

endmodule
